// File: rtl/task_read_raw_pkg.sv
// Shared types for the raw SD stream reader: FSM state encoding and error codes.
package task_read_raw_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST_SPI,
    WAIT_READY,
    CMD,
    WAIT_BLOCK,
    REQ_BYTE,
    ACK_BYTE,
    WAIT_BYTE,
    DONE,
    ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SPI     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // States in which the controller may raise spi_err against us.
  function automatic logic in_spi_window(input state_e s);
    return (s inside {WAIT_READY, CMD, WAIT_BLOCK, REQ_BYTE, ACK_BYTE, WAIT_BYTE});
  endfunction

endpackage

// File: rtl/busy_watchdog.sv
// Cycle counter for busy-waits: cleared on every state change, flags expiry
// on the LIMIT-th cycle spent in the same state.
module busy_watchdog #(
  parameter int unsigned LIMIT = 100,
  parameter int          CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic [CW-1:0] count_o,
  output logic          expired_o
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (count_q < LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = (count_q >= LAST);

endmodule

// File: rtl/task_read_raw_counter.sv
// Clearable up-counter; optionally saturates at all-ones instead of wrapping.
module task_read_raw_counter #(
  parameter int W        = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !(SATURATE && (&count_q))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/task_read_raw_stream.sv
// Streams num_bytes bytes from an SD card via multi-block read on the SPI SD controller.
// Define READ_RAW_CHECKSUM_EN to build the running 32-bit byte-sum checksum output.
module task_read_raw_stream
  import task_read_raw_pkg::*;
#(
  parameter int          CNT_W               = 32,
  parameter int          TIMER_W             = 64,
  parameter int unsigned TIMEOUT_CYCLES      = 2**24,
  parameter logic [31:0] DEFAULT_FIRST_BLOCK = 32'd50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        first_block_i,
  input  logic [CNT_W-1:0]   num_bytes,
  output logic               spi_ctl,
  output logic               rst_eluks,
  output logic               r_block,
  output logic               rst_spi,
  output logic               r_multi_block,
  output logic               r_byte,
  output logic [31:0]        block_addr,
  input  logic               spi_err,
  input  logic [7:0]         spi_data,
  input  logic               spi_busy,
  output logic [7:0]         data_out,
  output logic               data_valid,
  output logic [CNT_W-1:0]   bytes_done,
  output logic [31:0]        checksum,
  output logic               busy,
  output logic               end_signal,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [TIMER_W-1:0] exec_time
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [31:0]       block_addr_q;
  logic [CNT_W-1:0]  num_bytes_q;
  logic [7:0]        data_out_q;
  logic              data_valid_q;
  logic [1:0]        err_code_q, err_code_d;
  logic [WD_W-1:0]   wd_count;
  logic              wd_expired;
  logic              idle_like, in_read, start_acc, capture, more_bytes;

  // Handshake: start is a one-cycle request honoured only while idle_like;
  // end_signal stays high from DONE/ERROR until the next accepted start.
  assign idle_like  = (state_q inside {IDLE, DONE, ERROR});
  assign in_read    = (state_q inside {CMD, WAIT_BLOCK, REQ_BYTE, ACK_BYTE, WAIT_BYTE});
  assign start_acc  = start && idle_like;
  assign more_bytes = (bytes_done != num_bytes_q);
  // An error arriving with the final busy drop wins; the byte is dropped.
  assign capture    = (state_q == WAIT_BYTE) && !spi_busy && !spi_err;

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = RST_SPI;
          err_code_d = ERR_NONE;
        end
      end
      RST_SPI:    state_d = WAIT_READY;
      WAIT_READY: begin
        if (!spi_busy) begin
          state_d = CMD;
        end else if (wd_expired) begin
          state_d    = ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      CMD:        state_d = WAIT_BLOCK;
      WAIT_BLOCK: begin
        if (!spi_busy) begin
          state_d = REQ_BYTE;
        end else if (wd_expired) begin
          state_d    = ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      REQ_BYTE:   state_d = more_bytes ? ACK_BYTE : DONE;
      // A controller that never shows busy has already finished the byte.
      ACK_BYTE: begin
        if (spi_busy || (wd_count != '0)) begin
          state_d = WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        if (!spi_busy) begin
          state_d = REQ_BYTE;
        end else if (wd_expired) begin
          state_d    = ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      default:    state_d = IDLE;
    endcase
    if (in_spi_window(state_q) && spi_err) begin
      state_d    = ERROR;
      err_code_d = ERR_SPI;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      block_addr_q <= DEFAULT_FIRST_BLOCK;
      num_bytes_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      data_valid_q <= capture;
      if (start_acc) begin
        block_addr_q <= (first_block_i == '0) ? DEFAULT_FIRST_BLOCK : first_block_i;
        num_bytes_q  <= num_bytes;
      end
      if (capture) begin
        data_out_q <= spi_data;
      end
    end
  end

  busy_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .CW    (WD_W)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_d != state_q),
    .count_o   (wd_count),
    .expired_o (wd_expired)
  );

  task_read_raw_counter #(
    .W        (CNT_W),
    .SATURATE (1'b1)
  ) u_bytes_done (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start_acc),
    .en_i    (capture),
    .count_o (bytes_done)
  );

  task_read_raw_counter #(
    .W        (TIMER_W),
    .SATURATE (1'b0)
  ) u_exec_time (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start_acc),
    .en_i    (in_read),
    .count_o (exec_time)
  );

`ifdef READ_RAW_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (start_acc) begin
      checksum_q <= '0;
    end else if (capture) begin
      checksum_q <= checksum_q + {24'd0, spi_data};
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign spi_ctl       = 1'b0;
  assign rst_eluks     = 1'b1;
  assign r_block       = 1'b0;
  assign rst_spi       = (state_q == RST_SPI);
  assign r_multi_block = in_read;
  assign r_byte        = (state_q == REQ_BYTE) && more_bytes;
  assign block_addr    = block_addr_q;
  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign busy          = !idle_like;
  assign end_signal    = (state_q inside {DONE, ERROR});
  assign error         = (state_q == ERROR);
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_task_read_raw_stream.sv
// Randomized scoreboard bench for task_read_raw_stream with a behavioural SPI SD controller model.
module tb_task_read_raw_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] first_block_i = '0;
  logic [31:0] num_bytes = '0;
  logic        spi_ctl, rst_eluks, r_block, rst_spi, r_multi_block, r_byte;
  logic [31:0] block_addr;
  logic        spi_err = 1'b0;
  logic [7:0]  spi_data = '0;
  logic        spi_busy = 1'b0;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [31:0] bytes_done;
  logic [31:0] checksum;
  logic        busy, end_signal, error;
  logic [1:0]  err_code;
  logic [63:0] exec_time;

  task_read_raw_stream #(
    .CNT_W          (32),
    .TIMER_W        (64),
    .TIMEOUT_CYCLES (100),
    .DEFAULT_FIRST_BLOCK (32'd50)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start),
    .first_block_i (first_block_i), .num_bytes (num_bytes),
    .spi_ctl (spi_ctl), .rst_eluks (rst_eluks), .r_block (r_block),
    .rst_spi (rst_spi), .r_multi_block (r_multi_block), .r_byte (r_byte),
    .block_addr (block_addr), .spi_err (spi_err), .spi_data (spi_data),
    .spi_busy (spi_busy), .data_out (data_out), .data_valid (data_valid),
    .bytes_done (bytes_done), .checksum (checksum), .busy (busy),
    .end_signal (end_signal), .error (error), .err_code (err_code),
    .exec_time (exec_time)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_block;
  logic [31:0] exp_ck;
  int          base_strobes, base_rst, base_cmd;

  // Controller model knobs (written by the stimulus thread only)
  logic [7:0]  byte_tab[0:15];
  int          err_idx = -1;
  logic        stuck_mode = 1'b0;
  logic        slow_mode = 1'b0;

  // Observations (written by model/monitor threads only)
  int          strobes = 0;
  int          rst_pulses = 0;
  int          cmd_count = 0;
  logic        mb_after_err = 1'b1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Behavioural SPI SD controller: busy for a while after each request.
  initial begin
    int busy_cnt;
    int byte_idx;
    logic mb_prev;
    logic err_pending;
    busy_cnt = 0; byte_idx = 0; mb_prev = 1'b0; err_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0; byte_idx = 0; mb_prev = 1'b0; err_pending = 1'b0;
        spi_busy = 1'b0; spi_err = 1'b0;
      end else begin
        if (spi_err) begin
          spi_err = 1'b0;
          mb_after_err = r_multi_block;
        end
        if (rst_spi) begin
          busy_cnt = $urandom_range(1, 4);
        end else if (r_multi_block && !mb_prev) begin
          byte_idx = 0;
          err_pending = 1'b0;
          busy_cnt = stuck_mode ? 1000 : $urandom_range(1, 6);
        end else if (r_byte) begin
          spi_data = byte_tab[byte_idx];
          if (byte_idx == err_idx) begin
            err_pending = 1'b1;
            busy_cnt = 2;
          end else begin
            busy_cnt = slow_mode ? 4 : $urandom_range(0, 4);
          end
          byte_idx++;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0 && err_pending) begin
            spi_err = 1'b1;
            err_pending = 1'b0;
          end
        end
        spi_busy = (busy_cnt > 0);
        mb_prev = r_multi_block;
      end
    end
  end

  // Monitor: pops the expected queue on every data strobe.
  initial begin
    logic mon_mb_prev;
    logic [7:0] e;
    mon_mb_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rst_spi) rst_pulses++;
        if (r_multi_block && !mon_mb_prev) cmd_count++;
        if (data_valid) begin
          strobes++;
          if (exp_q.size() == 0) begin
            check("strobe_unexpected", {56'd0, data_out}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("data_out", {56'd0, data_out}, {56'd0, e});
          end
        end
      end
      mon_mb_prev = r_multi_block;
    end
  end

  // Driver tasks
  task automatic fill_random();
    for (int i = 0; i < 16; i++) byte_tab[i] = 8'($urandom);
  endtask

  task automatic start_read(input logic [31:0] first, input int num, input int n_exp);
    exp_block = (first == 32'd0) ? 32'd50 : first;
    exp_ck = '0;
    for (int i = 0; i < n_exp; i++) begin
      exp_q.push_back(byte_tab[i]);
      exp_ck = exp_ck + {24'd0, byte_tab[i]};
    end
    base_strobes = strobes; base_rst = rst_pulses; base_cmd = cmd_count;
    @(negedge clk);
    first_block_i = first; num_bytes = num; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_rst_spi", rst_spi, 1);
    check("start_exec_time", exec_time, 0);
    check("start_bytes_done", bytes_done, 0);
    check("start_block_addr", block_addr, exp_block);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 3000 && !end_signal; i++) @(negedge clk);
    check("end_reached", end_signal, 1);
  endtask

  task automatic check_done(input int n_done, input logic exp_err, input logic [1:0] exp_code);
    logic [31:0] ck;
    ck = exp_ck;
`ifndef READ_RAW_CHECKSUM_EN
    ck = '0;
`endif
    check("error", error, exp_err);
    check("err_code", err_code, exp_code);
    check("bytes_done", bytes_done, n_done);
    check("block_addr", block_addr, exp_block);
    check("checksum", checksum, ck);
    check("busy_low", busy, 0);
    check("strobe_count", strobes - base_strobes, n_done);
    check("scoreboard_empty", exp_q.size(), 0);
    check("rst_spi_pulses", rst_pulses - base_rst, 1);
    check("cmd_issued", cmd_count - base_cmd, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {spi_ctl, rst_eluks, r_block, rst_spi, r_multi_block, r_byte}, 6'b010000);
    check({tag, "_status"}, {busy, end_signal, error, err_code, data_valid}, 0);
    check({tag, "_block_addr"}, block_addr, 50);
    check({tag, "_counts"}, {bytes_done, checksum}, 0);
    check({tag, "_exec_time"}, exec_time, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_data_out", data_out, 0);

    // Four known bytes from the default block
    byte_tab[0] = 8'h11; byte_tab[1] = 8'h22; byte_tab[2] = 8'h33; byte_tab[3] = 8'h44;
    start_read(32'd0, 4, 4);
    wait_end();
    check_done(4, 1'b0, 2'd0);

    // Zero-length read still issues CMD
    fill_random();
    start_read(32'd21, 0, 0);
    wait_end();
    check_done(0, 1'b0, 2'd0);

    // spi_err coincides with completion of the third byte
    fill_random();
    err_idx = 2;
    start_read(32'h100, 8, 2);
    wait_end();
    check_done(2, 1'b1, 2'd1);
    check("mb_drop_after_err", mb_after_err, 0);
    err_idx = -1;

    // Controller stuck busy after CMD -> watchdog
    stuck_mode = 1'b1;
    start_read(32'd12, 3, 0);
    for (int i = 0; i < 200 && !r_multi_block; i++) @(negedge clk);
    n = 0;
    for (int i = 0; i < 500 && !error; i++) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, 101);
    check("timeout_exec_time", exec_time, 101);
    check_done(0, 1'b1, 2'd2);
    stuck_mode = 1'b0;

    // Asynchronous reset in WAIT_BYTE, then a clean 2-byte read
    fill_random();
    slow_mode = 1'b1;
    start_read(32'd0, 5, 5);
    for (int i = 0; i < 200 && !r_byte; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    slow_mode = 1'b0;
    fill_random();
    start_read(32'd0, 2, 2);
    wait_end();
    check_done(2, 1'b0, 2'd0);

    // start while busy is ignored; start from DONE re-arms
    fill_random();
    start_read(32'd9, 6, 6);
    repeat (5) @(negedge clk);
    first_block_i = 32'd3; num_bytes = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end();
    check_done(6, 1'b0, 2'd0);
    fill_random();
    start_read(32'd7, 3, 3);
    wait_end();
    check_done(3, 1'b0, 2'd0);

    // Randomized reads
    for (int k = 0; k < 6; k++) begin
      int num;
      logic [31:0] fb;
      fill_random();
      num = $urandom_range(1, 12);
      fb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      start_read(fb, num, num);
      wait_end();
      check_done(num, 1'b0, 2'd0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
